// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand/control and HI/LO result bundle for muldiv_unit.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] Adat;
    logic [31:0] Bdat;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdat;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0;
    modport master (output start, op, Adat, Bdat, hi_we, lo_we, wdat,
                    input  hi, lo, busy, done, div0);
    modport slave  (input  start, op, Adat, Bdat, hi_we, lo_we, wdat,
                    output hi, lo, busy, done, div0);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit shift-add multiplier / restoring divider
// with architectural HI/LO registers and MTHI/MTLO writes.
module muldiv_unit (
    input logic clk,
    input logic rst_n,
    muldiv_unit_if.slave m
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t      state, state_n;
    logic [31:0] hreg, lreg, breg, hi_r, lo_r, ddf;
    logic [4:0]  cnt;
    logic        is_div, sa, sb, done_r, div0_r, a_neg, b_neg, dge, bz;
    logic [32:0] msum, dsh;
    logic [63:0] prod;
    assign a_neg = ~m.op[0] & m.Adat[31];
    assign b_neg = ~m.op[0] & m.Bdat[31];
    // hreg/lreg hold {partial product, multiplier} or {remainder, dividend/quotient}
    assign msum = {1'b0, hreg} + (lreg[0] ? {1'b0, breg} : 33'd0);
    assign dsh  = {hreg, lreg[31]};
    assign dge  = dsh >= {1'b0, breg};
    assign ddf  = dsh[31:0] - breg;
    assign bz   = breg == 32'd0;
    assign prod = (sa ^ sb) ? -{hreg, lreg} : {hreg, lreg};
    assign m.hi   = hi_r;
    assign m.lo   = lo_r;
    assign m.busy = state != IDLE;
    assign m.done = done_r;
    assign m.div0 = div0_r;
    always_comb begin
        state_n = state == IDLE ? (m.start ? (m.op[1] ? DIV : MUL) : IDLE) :
                  state == FIX  ? IDLE : (cnt == 5'd31 ? FIX : state);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {hreg, lreg, breg, hi_r, lo_r} <= '0;
            {cnt, is_div, sa, sb, done_r, div0_r} <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE:
                    if (m.start) begin
                        is_div <= m.op[1];
                        sa     <= a_neg;
                        sb     <= b_neg;
                        hreg   <= '0;
                        lreg   <= a_neg ? -m.Adat : m.Adat;
                        breg   <= b_neg ? -m.Bdat : m.Bdat;
                        cnt    <= '0;
                    end else begin
                        if (m.hi_we) hi_r <= m.wdat;
                        if (m.lo_we) lo_r <= m.wdat;
                    end
                MUL: begin
                    hreg <= msum[32:1];
                    lreg <= {msum[0], lreg[31:1]};
                    cnt  <= cnt + 5'd1;
                end
                DIV: begin
                    hreg <= dge ? ddf : dsh[31:0];
                    lreg <= {lreg[30:0], dge};
                    cnt  <= cnt + 5'd1;
                end
                FIX: begin
                    done_r <= 1'b1;
                    div0_r <= is_div & bz;
                    // divide-by-zero leaves |A| as remainder, so hi recovers Adat after sign fix
                    if (is_div) begin
                        hi_r <= sa ? -hreg : hreg;
                        lo_r <= bz ? '1 : ((sa ^ sb) ? -lreg : lreg);
                    end else begin
                        {hi_r, lo_r} <= prod;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    muldiv_unit_if bus ();
    muldiv_unit dut (.clk(clk), .rst_n(rst_n), .m(bus));
    always #5 clk = ~clk;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIVS = 2'b10, DIVU = 2'b11;

    // Drives one operation from edge 0 through edge 33; ok reports busy/done timing.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output logic ok);
        bus.start = 1'b1; bus.op = op; bus.Adat = a; bus.Bdat = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ok = 1'b1;
        repeat (32) begin
            @(posedge clk); #1;
            if (!bus.busy || bus.done) ok = 1'b0;
        end
        @(posedge clk); #1;
        if (!bus.done || bus.busy) ok = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++; if ({bus.hi, bus.lo} !== 64'd0) $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo}); else passed++;
        total++; if ({bus.busy, bus.done, bus.div0} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.div0}); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_multu;
        logic ok;
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, ok);
        total++; if (ok !== 1'b1) $display("FAIL multu_timing: got %b want 1", ok); else passed++;
        total++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFE_00000001) $display("FAIL multu_result: got %h want fffffffe00000001", {bus.hi, bus.lo}); else passed++;
        @(posedge clk); #1;
        total++; if (bus.done !== 1'b0) $display("FAIL multu_done_pulse: got %b want 0", bus.done); else passed++;
    endtask

    task automatic test_back_to_back;
        logic ok;
        run_op(MULT, 32'hFFFFFFFD, 32'd7, ok);
        total++; if ({ok, bus.hi, bus.lo} !== {1'b1, 64'hFFFFFFFF_FFFFFFEB}) $display("FAIL mult_neg: got %b %h want 1 ffffffffffffffeb", ok, {bus.hi, bus.lo}); else passed++;
        run_op(DIVU, 32'd100, 32'd7, ok);
        total++; if ({ok, bus.hi, bus.lo} !== {1'b1, 32'd2, 32'd14}) $display("FAIL divu_b2b: got %b %h want 1 000000020000000e", ok, {bus.hi, bus.lo}); else passed++;
    endtask

    task automatic test_div_signed;
        logic ok;
        run_op(DIVS, 32'hFFFFFFF9, 32'd2, ok);
        total++; if ({ok, bus.hi, bus.lo, bus.div0} !== {1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}) $display("FAIL div_neg: got %b %h %h %b want 1 ffffffff fffffffd 0", ok, bus.hi, bus.lo, bus.div0); else passed++;
        run_op(DIVS, 32'h80000000, 32'hFFFFFFFF, ok);
        total++; if ({ok, bus.hi, bus.lo, bus.div0} !== {1'b1, 32'h0, 32'h80000000, 1'b0}) $display("FAIL div_wrap: got %b %h %h %b want 1 0 80000000 0", ok, bus.hi, bus.lo, bus.div0); else passed++;
        run_op(DIVS, 32'd7, 32'hFFFFFFFE, ok);
        total++; if ({bus.hi, bus.lo} !== {32'd1, 32'hFFFFFFFD}) $display("FAIL div_negdivisor: got %h want 00000001fffffffd", {bus.hi, bus.lo}); else passed++;
    endtask

    task automatic test_div0;
        logic ok;
        run_op(DIVU, 32'd5, 32'd0, ok);
        total++; if ({ok, bus.hi, bus.lo, bus.div0} !== {1'b1, 32'd5, 32'hFFFFFFFF, 1'b1}) $display("FAIL divu_zero: got %b %h %h %b want 1 5 ffffffff 1", ok, bus.hi, bus.lo, bus.div0); else passed++;
        run_op(MULTU, 32'd2, 32'd3, ok);
        total++; if ({bus.hi, bus.lo, bus.div0} !== {32'd0, 32'd6, 1'b0}) $display("FAIL div0_clear: got %h %h %b want 0 6 0", bus.hi, bus.lo, bus.div0); else passed++;
        run_op(DIVS, 32'hFFFFFFF9, 32'd0, ok);
        total++; if ({bus.hi, bus.lo, bus.div0} !== {32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1}) $display("FAIL div_zero: got %h %h %b want fffffff9 ffffffff 1", bus.hi, bus.lo, bus.div0); else passed++;
    endtask

    task automatic test_mt_ignore;
        bus.start = 1'b1; bus.op = DIVU; bus.Adat = 32'd1000; bus.Bdat = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = MULTU; bus.hi_we = 1'b1; bus.wdat = 32'h1234;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hi_we = 1'b0;
        total++; if (bus.hi !== 32'hFFFFFFF9) $display("FAIL mthi_busy: got %h want fffffff9", bus.hi); else passed++;
        repeat (28) @(posedge clk);
        #1;
        total++; if ({bus.done, bus.hi, bus.lo} !== {1'b1, 32'd6, 32'd142}) $display("FAIL divu_unchanged: got %b %h %h want 1 6 8e", bus.done, bus.hi, bus.lo); else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL start_ignored: got busy %b want 0", bus.busy); else passed++;
        bus.lo_we = 1'b1; bus.wdat = 32'hABCD;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        total++; if ({bus.hi, bus.lo} !== {32'd6, 32'hABCD}) $display("FAIL mtlo: got %h %h want 6 abcd", bus.hi, bus.lo); else passed++;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdat = 32'h5A5A0F0F;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        total++; if ({bus.hi, bus.lo} !== {32'h5A5A0F0F, 32'h5A5A0F0F}) $display("FAIL mthilo: got %h %h want 5a5a0f0f 5a5a0f0f", bus.hi, bus.lo); else passed++;
        // MT strobe coinciding with an accepted start must be dropped
        bus.start = 1'b1; bus.op = MULTU; bus.Adat = 32'd2; bus.Bdat = 32'd3; bus.hi_we = 1'b1; bus.wdat = 32'hDEAD;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hi_we = 1'b0;
        total++; if ({bus.busy, bus.hi} !== {1'b1, 32'h5A5A0F0F}) $display("FAIL mthi_with_start: got %b %h want 1 5a5a0f0f", bus.busy, bus.hi); else passed++;
        repeat (33) @(posedge clk);
        #1;
        total++; if ({bus.done, bus.hi, bus.lo} !== {1'b1, 32'd0, 32'd6}) $display("FAIL multu_after_mt: got %b %h %h want 1 0 6", bus.done, bus.hi, bus.lo); else passed++;
    endtask

    task automatic test_reset_mid;
        logic ok;
        logic seen_done;
        bus.start = 1'b1; bus.op = MULT; bus.Adat = 32'hFFFFFFFD; bus.Bdat = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, 64'd0}) $display("FAIL async_reset: got %b%b %h %h want 00 0 0", bus.busy, bus.done, bus.hi, bus.lo); else passed++;
        seen_done = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1'b1;
        end
        total++; if (seen_done !== 1'b0) $display("FAIL reset_no_done: got %b want 0", seen_done); else passed++;
        rst_n = 1'b1;
        run_op(MULTU, 32'd4, 32'd5, ok);
        total++; if ({ok, bus.hi, bus.lo} !== {1'b1, 32'd0, 32'd20}) $display("FAIL post_reset_multu: got %b %h %h want 1 0 14", ok, bus.hi, bus.lo); else passed++;
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.Adat = '0; bus.Bdat = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdat = '0;
        test_reset;
        test_multu;
        test_back_to_back;
        test_div_signed;
        test_div0;
        test_mt_ignore;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
